// File: rtl/node_ram_arbiter.sv
// node_ram_arbiter
//    Shares one port of the node RAM among NREQ bus masters. Each requester has
//    its own address window, which is selected by the top address bit. Only one
//    transaction is in flight at a time. Winners are picked in IDLE only.
//    A read waits RD_LAT clocks for RAM data. Dropping the bus cycle during a
//    read aborts that read without an ack.
//
//    Optional feature macro: NODE_ARB_ROUND_ROBIN_EN
//       defined   : round-robin winner search starting after the last grant
//       undefined : fixed priority, lowest eligible index wins
//
// Ports
//    clk_i, rst_i   clock, synchronous active-high reset
//    req_cyc_i      per-requester bus cycle
//    req_stb_i      per-requester strobe
//    req_we_i       per-requester write enable
//    req_adr_i      requester i address at [i*AW +: AW]
//    req_dat_i      requester i write data at [i*DW +: DW]
//    req_ack_o      one-hot (or zero) acknowledge
//    req_dat_o      read data, zero outside the acked requester's slice
//    ram_en_o       RAM port enable
//    ram_we_o       RAM port write enable
//    ram_adr_o      RAM address (low RAW bits of the requester address)
//    ram_dat_o      RAM write data
//    ram_dat_i      RAM read data
//    busy_o         a transaction is in progress
//    grant_o        index of the current or most recent winner
module node_ram_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned AW      = 24,
   parameter int unsigned DW      = 8,
   parameter int unsigned RAW     = 17,
   parameter logic [7:0]  WIN_SEL = 8'b10,
   parameter int unsigned RD_LAT  = 3,
   localparam int unsigned GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NREQ-1:0]    req_cyc_i,
   input  logic [NREQ-1:0]    req_stb_i,
   input  logic [NREQ-1:0]    req_we_i,
   input  logic [NREQ*AW-1:0] req_adr_i,
   input  logic [NREQ*DW-1:0] req_dat_i,
   output logic [NREQ-1:0]    req_ack_o,
   output logic [NREQ*DW-1:0] req_dat_o,
   output logic               ram_en_o,
   output logic               ram_we_o,
   output logic [RAW-1:0]     ram_adr_o,
   output logic [DW-1:0]      ram_dat_o,
   input  logic [DW-1:0]      ram_dat_i,
   output logic               busy_o,
   output logic [GW-1:0]      grant_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WR_ISSUE = 2'd1,
      S_RD_WAIT  = 2'd2,
      S_ACK      = 2'd3
   } state_t;

   state_t              state_q;
   logic [NREQ-1:0]     ack_q;
   logic [NREQ*DW-1:0]  rdat_q;
   logic                ram_en_q;
   logic                ram_we_q;
   logic [RAW-1:0]      ram_adr_q;
   logic [DW-1:0]       ram_dat_q;
   logic [GW-1:0]       grant_q;
   logic [3:0]          cnt_q;

   // Winner candidate for the next IDLE cycle
   logic [NREQ-1:0]     elig;
   logic                win_found_d;
   logic [GW-1:0]       win_idx_d;
   logic                win_we_d;
   logic [RAW-1:0]      win_adr_d;
   logic [DW-1:0]       win_dat_d;
   int unsigned         scan_idx;

   // Address bits above RAW only feed the window decode of the top bit
   logic                adr_unused;
   assign adr_unused = ^req_adr_i;

`ifdef NODE_ARB_ROUND_ROBIN_EN
   logic [GW-1:0]       ptr_q;
`endif

   always_comb begin
      elig = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         elig[i] = req_cyc_i[i] & req_stb_i[i] &
                   (req_adr_i[i*AW + AW - 1] == WIN_SEL[i]);
      end
   end

   // Search order: after the last grant (round robin) or from index 0.
   always_comb begin
      win_found_d = 1'b0;
      win_idx_d   = '0;
      win_we_d    = 1'b0;
      win_adr_d   = '0;
      win_dat_d   = '0;
      scan_idx    = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef NODE_ARB_ROUND_ROBIN_EN
         scan_idx = 32'(ptr_q) + 1 + k;
         if (scan_idx >= NREQ) begin
            scan_idx = scan_idx - NREQ;
         end
`else
         scan_idx = k;
`endif
         if (!win_found_d && elig[scan_idx]) begin
            win_found_d = 1'b1;
            win_idx_d   = GW'(scan_idx);
            win_we_d    = req_we_i[scan_idx];
            win_adr_d   = req_adr_i[scan_idx*AW +: RAW];
            win_dat_d   = req_dat_i[scan_idx*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         ack_q     <= '0;
         rdat_q    <= '0;
         ram_en_q  <= 1'b0;
         ram_we_q  <= 1'b0;
         ram_adr_q <= '0;
         ram_dat_q <= '0;
         grant_q   <= '0;
         cnt_q     <= '0;
`ifdef NODE_ARB_ROUND_ROBIN_EN
         ptr_q     <= GW'(NREQ - 1);
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_found_d) begin
                  ram_adr_q <= win_adr_d;
                  ram_dat_q <= win_dat_d;
                  ram_we_q  <= win_we_d;
                  ram_en_q  <= 1'b1;
                  grant_q   <= win_idx_d;
                  cnt_q     <= 4'(RD_LAT);
`ifdef NODE_ARB_ROUND_ROBIN_EN
                  ptr_q     <= win_idx_d;
`endif
                  state_q   <= win_we_d ? S_WR_ISSUE : S_RD_WAIT;
               end
            end
            S_WR_ISSUE: begin
               ram_we_q       <= 1'b0;
               ram_en_q       <= 1'b0;
               ack_q[grant_q] <= 1'b1;
               state_q        <= S_ACK;
            end
            S_RD_WAIT: begin
               // A dropped cycle wins over data arrival: the master has gone.
               if (!req_cyc_i[grant_q]) begin
                  ram_en_q <= 1'b0;
                  state_q  <= S_IDLE;
               end else if (cnt_q == 4'd1) begin
                  // rdat_q is all-zero here, so only the winner's slice is loaded
                  rdat_q[grant_q*DW +: DW] <= ram_dat_i;
                  ack_q[grant_q]           <= 1'b1;
                  ram_en_q                 <= 1'b0;
                  state_q                  <= S_ACK;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_ACK: begin
               if (!req_cyc_i[grant_q]) begin
                  ack_q   <= '0;
                  rdat_q  <= '0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               ack_q    <= '0;
               rdat_q   <= '0;
               ram_en_q <= 1'b0;
               ram_we_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ack_o = ack_q;
   assign req_dat_o = rdat_q;
   assign ram_en_o  = ram_en_q;
   assign ram_we_o  = ram_we_q;
   assign ram_adr_o = ram_adr_q;
   assign ram_dat_o = ram_dat_q;
   assign grant_o   = grant_q;
   assign busy_o    = (state_q != S_IDLE);

endmodule
